// File: rtl/ysyx_22050854_cache_mem_responder_pkg.sv
// ysyx_22050854_cache_pkg
// Definitions shared by ysyx_22050854_Dcache and its memory-side responder:
// the access type codes carried on rd_type/wr_type, the line geometry, and
// the responder state encoding.
package ysyx_22050854_cache_pkg;

  localparam logic [2:0] TYPE_BYTE  = 3'b000;
  localparam logic [2:0] TYPE_HALF  = 3'b001;
  localparam logic [2:0] TYPE_WORD  = 3'b010;
  localparam logic [2:0] TYPE_DWORD = 3'b011;
  localparam logic [2:0] TYPE_LINE  = 3'b100;

  localparam int LINE_BEATS  = 2;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR_BEAT
  } resp_state_e;

  // Codes 101..111 behave as a dword access, so only the line code is special.
  function automatic logic is_line(input logic [2:0] t);
    return t == TYPE_LINE;
  endfunction

endpackage

// File: rtl/ysyx_22050854_cache_mem_responder_if.sv
// ysyx_22050854_cache_mem_responder_if
// D-cache <-> memory responder bus.
//   master (cache):     drives rd_req/rd_type/rd_addr, wr_req/wr_type/wr_addr/
//                       wr_wstb/wr_data; receives rd_rdy, wr_rdy, ret_*.
//   slave  (responder): the mirror image.
interface ysyx_22050854_cache_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  rd_req;
  logic [2:0]            rd_type;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic                  ret_last;
  logic [DATA_W-1:0]     ret_data;
  logic                  wr_req;
  logic [2:0]            wr_type;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W/8-1:0]   wr_wstb;
  logic [2*DATA_W-1:0]   wr_data;
  logic                  wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/ysyx_22050854_cache_mem_responder.sv
// ysyx_22050854_cache_mem_responder
// Serves D-cache refills and writebacks from a single-port synchronous SRAM
// (1-cycle read latency). Reads return 64-bit beats on ret_*, writes become
// masked SRAM writes; no response is sent for writes.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   bus (slave)    cache request/return handshake
//   mem_en/mem_we  SRAM access strobe / write enable
//   mem_addr       SRAM dword index (byte address >> 3)
//   mem_wmask      SRAM byte write mask
//   mem_wdata      SRAM write data
//   mem_rdata      SRAM read data, valid the cycle after a read strobe
// Configuration macro: YSYX_22050854_CRITICAL_WORD_FIRST_EN -- when defined a
// line read returns the dword selected by rd_addr[3] first (wrap order);
// otherwise the low dword always comes first.
module ysyx_22050854_cache_mem_responder
  import ysyx_22050854_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050854_cache_mem_responder_if.slave bus,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-4:0]             mem_addr,
  output logic [DATA_W/8-1:0]           mem_wmask,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W    = ADDR_W - 3;
  localparam int BEAT_BIT = OFFSET_BITS - 3;

  resp_state_e            state_q, state_d;
  logic                   rdy_q;
  logic                   beat_q, beat_d;

  // Request latches; only meaningful outside IDLE, so they carry no reset.
  logic [2:0]             type_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_W/8-1:0]    wstb_q;
  logic [2*DATA_W-1:0]    wdata_q;

  logic                   accept_wr, accept_rd;
  logic                   line_q;
  logic                   first_beat;
  logic [IDX_W-2:0]       line_idx;

  // Write wins a simultaneous request so a dirty writeback lands before the
  // refill of the same line.
  assign accept_wr = (state_q == IDLE) && rdy_q && bus.wr_req;
  assign accept_rd = (state_q == IDLE) && rdy_q && bus.rd_req && !bus.wr_req;

  assign line_q   = is_line(type_q);
  assign line_idx = idx_q[IDX_W-1:BEAT_BIT];
`ifdef YSYX_22050854_CRITICAL_WORD_FIRST_EN
  assign first_beat = idx_q[0];
`else
  assign first_beat = 1'b0;
`endif

  assign bus.rd_rdy = rdy_q;
  assign bus.wr_rdy = rdy_q;

  // Control registers: state, handshake ready, beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      beat_q  <= beat_d;
    end
  end

  // Request capture at the accept edge.
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      type_q  <= bus.wr_type;
      idx_q   <= bus.wr_addr[ADDR_W-1:3];
      wstb_q  <= bus.wr_wstb;
      wdata_q <= bus.wr_data;
    end else if (accept_rd) begin
      type_q  <= bus.rd_type;
      idx_q   <= bus.rd_addr[ADDR_W-1:3];
    end
  end

  // Next state and outputs. All memory/return outputs are zero unless the
  // current state drives them, which also makes reset clear them at once.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wmask     = '0;
    mem_wdata     = '0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = '0;
    case (state_q)
      IDLE: begin
        beat_d = 1'b0;
        if (accept_wr)      state_d = WR_BEAT;
        else if (accept_rd) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = line_q ? {line_idx, first_beat} : idx_q;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        // Returns the beat read last cycle; for the first beat of a line the
        // second SRAM read overlaps it.
        bus.ret_valid = 1'b1;
        bus.ret_data  = mem_rdata;
        bus.ret_last  = !line_q || beat_q;
        if (line_q && !beat_q) begin
          mem_en   = 1'b1;
          mem_addr = {line_idx, ~first_beat};
          beat_d   = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      WR_BEAT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_q ? {line_idx, beat_q} : idx_q;
        mem_wmask = line_q ? '1 : wstb_q;
        mem_wdata = beat_q ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
        if (line_q && !beat_q) beat_d  = 1'b1;
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050854_cache_mem_responder.sv
module tb_ysyx_22050854_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en, mem_we;
  logic [28:0] mem_addr;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  ysyx_22050854_cache_mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ysyx_22050854_cache_mem_responder #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference memory: 64 dwords covering 0x8000_0000..0x8000_01FF.
  logic [63:0] ref_mem [64];
  logic [63:0] sram    [64];
  logic        preload = 1'b0;

  // Behavioural 1-cycle SRAM.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram[i] <= ref_mem[i];
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) sram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[5:0]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cwf_first(input logic [31:0] a);
`ifdef YSYX_22050854_CRITICAL_WORD_FIRST_EN
    return a[3];
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.rd_type = 3'd0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = 3'd0; bus.wr_addr = '0;
    bus.wr_wstb = '0;  bus.wr_data = '0;
  endtask

  // Called at a negedge; returns at a negedge where the responder is ready.
  task automatic wait_rdy();
    int n = 0;
    while (!(bus.rd_rdy && bus.wr_rdy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("rdy_timeout", {bus.rd_rdy, bus.wr_rdy}, 2'b11);
  endtask

  // Checks from the cycle after the accept edge; ends at a negedge in IDLE.
  task automatic rd_check(input logic [31:0] a, input logic [2:0] t);
    logic        line = (t == 3'b100);
    logic        f    = cwf_first(a);
    logic [5:0]  i0, i1;
    logic [28:0] a0;
    i0 = line ? {a[8:4], f}  : a[8:3];
    i1 = {a[8:4], ~f};
    a0 = line ? {a[31:4], f} : a[31:3];
    @(negedge clk);
    check_val("rd_t1_mem_en", {mem_en, mem_we}, 2'b10);
    check_val("rd_t1_mem_addr", mem_addr, a0);
    check_val("rd_t1_ret_valid", bus.ret_valid, 1'b0);
    check_val("rd_t1_rdy", bus.rd_rdy, 1'b0);
    @(negedge clk);
    check_val("rd_beat0_valid", bus.ret_valid, 1'b1);
    check_val("rd_beat0_data", bus.ret_data, ref_mem[i0]);
    check_val("rd_beat0_last", bus.ret_last, !line);
    if (line) begin
      @(negedge clk);
      check_val("rd_beat1_valid", bus.ret_valid, 1'b1);
      check_val("rd_beat1_data", bus.ret_data, ref_mem[i1]);
      check_val("rd_beat1_last", bus.ret_last, 1'b1);
    end
    @(negedge clk);
    check_val("rd_done_rdy", {bus.rd_rdy, bus.wr_rdy}, 2'b11);
    check_val("rd_done_valid", bus.ret_valid, 1'b0);
  endtask

  task automatic wr_check(input logic [31:0] a, input logic [2:0] t,
                          input logic [7:0] s, input logic [127:0] d);
    logic line = (t == 3'b100);
    for (int k = 0; k < (line ? 2 : 1); k++) begin
      @(negedge clk);
      check_val("wr_en_we", {mem_en, mem_we}, 2'b11);
      check_val("wr_addr", mem_addr, line ? {a[31:4], k[0]} : a[31:3]);
      check_val("wr_mask", mem_wmask, line ? 8'hFF : s);
      check_val("wr_data", mem_wdata, k == 0 ? d[63:0] : d[127:64]);
      check_val("wr_ret_valid", bus.ret_valid, 1'b0);
    end
    if (line) begin
      ref_mem[{a[8:4], 1'b0}] = d[63:0];
      ref_mem[{a[8:4], 1'b1}] = d[127:64];
    end else begin
      for (int b = 0; b < 8; b++)
        if (s[b]) ref_mem[a[8:3]][b*8 +: 8] = d[b*8 +: 8];
    end
    @(negedge clk);
    check_val("wr_done_rdy", {bus.rd_rdy, bus.wr_rdy, mem_en}, 3'b110);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] t);
    wait_rdy();
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_type = t;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    rd_check(a, t);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] t,
                          input logic [7:0] s, input logic [127:0] d);
    wait_rdy();
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = t;
    bus.wr_wstb = s; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    wr_check(a, t, s, d);
  endtask

  // Read and write raised together: the write must be served first and the
  // read, still held, is accepted as soon as the responder is idle again.
  task automatic do_both(input logic [31:0] ra, input logic [2:0] rt,
                         input logic [31:0] wa, input logic [2:0] wt,
                         input logic [7:0] s, input logic [127:0] d);
    wait_rdy();
    bus.rd_req = 1'b1; bus.rd_addr = ra; bus.rd_type = rt;
    bus.wr_req = 1'b1; bus.wr_addr = wa; bus.wr_type = wt;
    bus.wr_wstb = s; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    wr_check(wa, wt, s, d);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    rd_check(ra, rt);
  endtask

  logic [63:0]  a_val, b_val;
  logic [127:0] line_d;

  initial begin
    idle_inputs();
    for (int i = 0; i < 64; i++) ref_mem[i] = {$urandom, $urandom};
    a_val = 64'hAAAA_0000_1111_0010;
    b_val = 64'hBBBB_0000_2222_0018;
    ref_mem[2] = a_val;
    ref_mem[3] = b_val;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;

    // Reset state.
    @(negedge clk);
    check_val("reset_outputs",
              {bus.rd_rdy, bus.wr_rdy, bus.ret_valid, bus.ret_last, bus.ret_data,
               mem_en, mem_we, mem_addr, mem_wmask, mem_wdata}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rdy_after_reset", {bus.rd_rdy, bus.wr_rdy}, 2'b11);

    // Line read at 0x8000_0018 (A at 0x10, B at 0x18).
    do_read(32'h8000_0018, 3'b100);
    // Word read returns the raw aligned dword.
    do_read(32'h8000_0004, 3'b010);
    // Line write then read back.
    line_d = {64'hD1D1_D1D1_0000_0028, 64'hD0D0_D0D0_0000_0020};
    do_write(32'h8000_0020, 3'b100, 8'h00, line_d);
    do_read(32'h8000_0020, 3'b100);
    // Byte write touching only byte 2.
    do_write(32'h8000_0000, 3'b000, 8'h04, 128'h00AB_0000);
    do_read(32'h8000_0000, 3'b011);
    // Simultaneous read + write to one line.
    do_both(32'h8000_0048, 3'b100, 32'h8000_0040, 3'b100, 8'h00,
            {64'h5EC0_4D00_0000_0048, 64'h5EC0_4D00_0000_0040});

    // Reset in the middle of a line write.
    wait_rdy();
    bus.wr_req = 1'b1; bus.wr_addr = 32'h8000_0060; bus.wr_type = 3'b100;
    bus.wr_wstb = 8'h00; bus.wr_data = {64'hDEAD_0000_0000_0068, 64'hBEEF_0000_0000_0060};
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check_val("rstwr_beat0", {mem_en, mem_we, mem_addr}, {2'b11, 29'h1000_000C});
    ref_mem[12] = 64'hBEEF_0000_0000_0060;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_val("rstwr_outputs",
              {bus.rd_rdy, bus.wr_rdy, bus.ret_valid, bus.ret_last, bus.ret_data,
               mem_en, mem_we, mem_addr, mem_wmask, mem_wdata}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rstwr_rdy_after", {bus.rd_rdy, bus.wr_rdy}, 2'b11);
    do_read(32'h8000_0060, 3'b100);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [31:0]  ra, wa;
      logic [2:0]   rt, wt;
      logic [7:0]   s;
      logic [127:0] d;
      int           op;
      ra = 32'h8000_0000 | ($urandom & 32'h1FF);
      wa = 32'h8000_0000 | ($urandom & 32'h1FF);
      rt = 3'($urandom_range(0, 7));
      wt = 3'($urandom_range(0, 7));
      s  = 8'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      op = $urandom_range(0, 2);
      if (op == 0)      do_read(ra, rt);
      else if (op == 1) do_write(wa, wt, s, d);
      else              do_both({wa[31:4], ra[3:0]}, rt, wa, wt, s, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
